// File: rtl/ddr3_seq_arb_pkg.sv
// Shared constants for the sequencer RAM arbiter: port ids and arbitration modes.
package ddr3_seq_arb_pkg;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_e;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

endpackage

// File: rtl/ddr3_seq_arb2_grant.sv
// Two-way grant logic: round-robin, or port-0 fixed priority with a starvation guard for port 1.
module ddr3_seq_arb2_grant
  import ddr3_seq_arb_pkg::*;
#(
  parameter int unsigned PRIO_MODE    = PRIO_RR,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_grant0,
  output logic o_grant1
);

  port_id_e   r_last;
  port_id_e   w_last_nxt;
  logic [7:0] r_starve;
  logic [7:0] w_starve_nxt;
  logic       w_pick1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last   <= PORT1;
      r_starve <= '0;
    end else begin
      r_last   <= w_last_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    w_pick1      = 1'b0;
    o_grant0     = 1'b0;
    o_grant1     = 1'b0;
    w_last_nxt   = r_last;
    w_starve_nxt = r_starve;

    // w_pick1 only matters when both ports request in the same cycle
    if (PRIO_MODE == PRIO_FIXED) begin
      w_pick1 = (r_starve == 8'(STARVE_LIMIT));
    end else begin
      w_pick1 = (r_last == PORT0);
    end

    if (!reset) begin
      if (i_req0 && i_req1) begin
        o_grant0 = ~w_pick1;
        o_grant1 = w_pick1;
      end else begin
        o_grant0 = i_req0;
        o_grant1 = i_req1;
      end
    end

    if (o_grant1) begin
      w_last_nxt = PORT1;
    end else if (o_grant0) begin
      w_last_nxt = PORT0;
    end

    if (PRIO_MODE == PRIO_FIXED) begin
      if (o_grant1 || !i_req1) begin
        w_starve_nxt = '0;
      end else if (o_grant0) begin
        w_starve_nxt = r_starve + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ddr3_seq_ram_arbiter.sv
// Shares the sequencer's single-port byte-enabled RAM between two Avalon-MM masters,
// muxing the granted port onto the RAM and routing 1-cycle-latency read data back.
module ddr3_seq_ram_arbiter
  import ddr3_seq_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned PRIO_MODE    = PRIO_RR,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s0_address,
  input  logic [DATA_W/8-1:0]   s0_byteenable,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [DATA_W-1:0]     s0_writedata,
  output logic                  s0_waitrequest,
  output logic [DATA_W-1:0]     s0_readdata,
  output logic                  s0_readdatavalid,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata
);

  logic     w_req0;
  logic     w_req1;
  logic     w_grant0;
  logic     w_grant1;
  logic     w_rd_acc;
  logic     r_rd_vld;
  port_id_e r_rd_id;

  assign w_req0 = s0_read | s0_write;
  assign w_req1 = s1_read | s1_write;

  ddr3_seq_arb2_grant #(
    .PRIO_MODE    (PRIO_MODE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .reset    (reset),
    .i_req0   (w_req0),
    .i_req1   (w_req1),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  // A request with both read and write set is executed as a write
  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    ram_write      = 1'b0;
    if (w_grant1) begin
      ram_address    = s1_address;
      ram_writedata  = s1_writedata;
      ram_write      = s1_write;
      ram_byteenable = s1_write ? s1_byteenable : '1;
    end else if (w_grant0) begin
      ram_address    = s0_address;
      ram_writedata  = s0_writedata;
      ram_write      = s0_write;
      ram_byteenable = s0_write ? s0_byteenable : '1;
    end
  end

  assign ram_chipselect = w_grant0 | w_grant1;
  assign ram_clken      = 1'b1;
  assign w_rd_acc       = ram_chipselect & ~ram_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld <= 1'b0;
      r_rd_id  <= PORT0;
    end else begin
      r_rd_vld <= w_rd_acc;
      r_rd_id  <= w_grant1 ? PORT1 : PORT0;
    end
  end

  // Gating with reset drops a read that was accepted just before reset asserted
  assign s0_waitrequest   = reset | (w_req0 & ~w_grant0);
  assign s1_waitrequest   = reset | (w_req1 & ~w_grant1);
  assign s0_readdatavalid = ~reset & r_rd_vld & (r_rd_id == PORT0);
  assign s1_readdatavalid = ~reset & r_rd_vld & (r_rd_id == PORT1);
  assign s0_readdata      = ram_readdata;
  assign s1_readdata      = ram_readdata;

endmodule

// File: tb/tb_ddr3_seq_ram_arbiter.sv
// Bench for ddr3_seq_ram_arbiter: a round-robin and a fixed-priority instance, each driven
// by its own masters and RAM, checked every cycle against a transaction-level model.
module tb_ddr3_seq_ram_arbiter;
  import ddr3_seq_arb_pkg::*;

  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LIM = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] i_addr [2][2];
  logic [BW-1:0] i_be   [2][2];
  logic          i_rd   [2][2];
  logic          i_wr   [2][2];
  logic [DW-1:0] i_wd   [2][2];
  logic          o_wait [2][2];
  logic          o_rdv  [2][2];
  logic [DW-1:0] o_rdata[2][2];
  logic [AW-1:0] ram_addr[2];
  logic [BW-1:0] ram_be  [2];
  logic [DW-1:0] ram_wd  [2];
  logic [DW-1:0] ram_rd  [2];
  logic          ram_cs  [2];
  logic          ram_we  [2];
  logic          ram_ce  [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    ddr3_seq_ram_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .PRIO_MODE    ((m == 0) ? PRIO_RR : PRIO_FIXED),
      .STARVE_LIMIT (LIM)
    ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .s0_address       (i_addr[m][0]),
      .s0_byteenable    (i_be[m][0]),
      .s0_read          (i_rd[m][0]),
      .s0_write         (i_wr[m][0]),
      .s0_writedata     (i_wd[m][0]),
      .s0_waitrequest   (o_wait[m][0]),
      .s0_readdata      (o_rdata[m][0]),
      .s0_readdatavalid (o_rdv[m][0]),
      .s1_address       (i_addr[m][1]),
      .s1_byteenable    (i_be[m][1]),
      .s1_read          (i_rd[m][1]),
      .s1_write         (i_wr[m][1]),
      .s1_writedata     (i_wd[m][1]),
      .s1_waitrequest   (o_wait[m][1]),
      .s1_readdata      (o_rdata[m][1]),
      .s1_readdatavalid (o_rdv[m][1]),
      .ram_address      (ram_addr[m]),
      .ram_byteenable   (ram_be[m]),
      .ram_writedata    (ram_wd[m]),
      .ram_chipselect   (ram_cs[m]),
      .ram_write        (ram_we[m]),
      .ram_clken        (ram_ce[m]),
      .ram_readdata     (ram_rd[m])
    );
  end

  // Single-port RAM with byte enables and one cycle of read latency
  logic [DW-1:0] fx_mem [2][512] = '{default: '0};
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (ram_cs[m] && ram_ce[m]) begin
        if (ram_we[m]) begin
          for (int b = 0; b < BW; b++)
            if (ram_be[m][b]) fx_mem[m][ram_addr[m]][8*b +: 8] <= ram_wd[m][8*b +: 8];
        end else begin
          ram_rd[m] <= fx_mem[m][ram_addr[m]];
        end
      end
    end
  end

  // Reference model state
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_illegal = 0;
  int            m_last  [2];
  int            m_starve[2];
  bit            m_pv    [2];
  int            m_pid   [2];
  logic [DW-1:0] m_pdata [2];
  logic [DW-1:0] shadow  [2][512] = '{default: '0};
  int            obs_g   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(int m, bit r0, bit r1);
    if (r0 && r1) begin
      if (m == 0) return (m_last[m] == 0) ? 1 : 0;
      return (m_starve[m] == LIM) ? 1 : 0;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic new_req(int m, int p, bit rd);
    i_rd[m][p]   = rd;
    i_wr[m][p]   = !rd;
    i_addr[m][p] = AW'($urandom_range(0, 15));
    i_be[m][p]   = BW'($urandom);
    i_wd[m][p]   = $urandom;
  endtask

  // One bus cycle: check outputs mid-cycle, then advance the model past the clock edge
  task automatic step(input bit rst);
    int    g [2];
    bit    q0[2];
    bit    q1[2];
    bit    exp_v;
    string t;
    reset = rst;
    #3;
    for (int m = 0; m < 2; m++) begin
      q0[m] = i_rd[m][0] | i_wr[m][0];
      q1[m] = i_rd[m][1] | i_wr[m][1];
      g[m]  = rst ? -1 : model_grant(m, q0[m], q1[m]);
      if (!rst && i_rd[m][0] && i_wr[m][0]) begin
        n_illegal++;
        $display("note: inst%0d s0 read+write together, executed as write", m);
      end
      t = $sformatf("inst%0d t=%0t", m, $time);
      check({t, " s0_waitrequest"}, o_wait[m][0], rst ? 1 : (q0[m] && g[m] != 0));
      check({t, " s1_waitrequest"}, o_wait[m][1], rst ? 1 : (q1[m] && g[m] != 1));
      check({t, " ram_chipselect"}, ram_cs[m], g[m] >= 0);
      check({t, " ram_write"}, ram_we[m], (g[m] >= 0) ? i_wr[m][g[m]] : 1'b0);
      check({t, " ram_clken"}, ram_ce[m], 1);
      if (g[m] >= 0) begin
        check({t, " ram_address"}, ram_addr[m], i_addr[m][g[m]]);
        check({t, " ram_byteenable"}, ram_be[m], i_wr[m][g[m]] ? i_be[m][g[m]] : 4'hF);
        if (i_wr[m][g[m]]) check({t, " ram_writedata"}, ram_wd[m], i_wd[m][g[m]]);
      end
      for (int p = 0; p < 2; p++) begin
        exp_v = !rst && m_pv[m] && (m_pid[m] == p);
        check($sformatf("%s s%0d_readdatavalid", t, p), o_rdv[m][p], exp_v);
        if (exp_v) check($sformatf("%s s%0d_readdata", t, p), o_rdata[m][p], m_pdata[m]);
      end
      obs_g[m] = !ram_cs[m] ? -1 : (o_wait[m][0] ? 1 : 0);
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_last[m]   = 1;
        m_starve[m] = 0;
        m_pv[m]     = 0;
      end else begin
        m_pv[m] = 0;
        if (g[m] >= 0) begin
          if (i_wr[m][g[m]]) begin
            for (int b = 0; b < BW; b++)
              if (i_be[m][g[m]][b])
                shadow[m][i_addr[m][g[m]]][8*b +: 8] = i_wd[m][g[m]][8*b +: 8];
          end else begin
            m_pv[m]    = 1;
            m_pid[m]   = g[m];
            m_pdata[m] = shadow[m][i_addr[m][g[m]]];
          end
          m_last[m]       = g[m];
          i_rd[m][g[m]]   = 1'b0;
          i_wr[m][g[m]]   = 1'b0;
        end
        if (g[m] == 1 || !q1[m]) m_starve[m] = 0;
        else if (g[m] == 0)      m_starve[m] = m_starve[m] + 1;
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_last[m] = 1; m_starve[m] = 0; m_pv[m] = 0; m_pid[m] = 0; m_pdata[m] = '0;
      for (int p = 0; p < 2; p++) begin
        i_rd[m][p] = 0; i_wr[m][p] = 0; i_addr[m][p] = '0; i_be[m][p] = '0; i_wd[m][p] = '0;
      end
    end

    // Reset with no requests
    repeat (3) step(1);

    // Partial write then read-back on port 0
    for (int m = 0; m < 2; m++) begin
      i_wr[m][0] = 1; i_addr[m][0] = 9'd5; i_wd[m][0] = 32'hDEADBEEF; i_be[m][0] = 4'b0011;
    end
    step(0);
    for (int m = 0; m < 2; m++) begin
      i_rd[m][0] = 1; i_addr[m][0] = 9'd5;
    end
    step(0);
    step(0);
    for (int m = 0; m < 2; m++)
      check($sformatf("inst%0d readback low16", m), o_rdata[m][0][15:0], 16'hBEEF);

    // Continuous reads from both ports after a fresh reset
    step(1);
    for (int c = 0; c < 8; c++) begin
      for (int m = 0; m < 2; m++)
        for (int p = 0; p < 2; p++)
          if (!i_rd[m][p] && !i_wr[m][p]) new_req(m, p, 1);
      step(0);
      check($sformatf("rr grant c%0d", c), obs_g[0], c % 2);
      check($sformatf("fixed grant c%0d", c), obs_g[1], (c % 4 == 3) ? 1 : 0);
    end
    repeat (4) step(0);

    // Port-1 read accepted, then reset drops its return; first tie afterwards goes to port 0
    for (int m = 0; m < 2; m++) begin
      i_rd[m][1] = 1; i_addr[m][1] = 9'd7;
    end
    step(0);
    step(1);
    step(1);
    for (int m = 0; m < 2; m++) begin
      new_req(m, 0, 1);
      new_req(m, 1, 1);
    end
    step(0);
    check("rr post-reset tie", obs_g[0], 0);
    check("fixed post-reset tie", obs_g[1], 0);
    repeat (3) step(0);

    // Read and write asserted together on port 0
    for (int m = 0; m < 2; m++) begin
      new_req(m, 0, 0);
      i_rd[m][0] = 1;
    end
    step(0);
    step(0);
    check("illegal rd+wr seen", n_illegal, 2);

    // Randomised traffic
    for (int c = 0; c < 300; c++) begin
      for (int m = 0; m < 2; m++)
        for (int p = 0; p < 2; p++)
          if (!i_rd[m][p] && !i_wr[m][p] && $urandom_range(0, 1) == 1)
            new_req(m, p, $urandom_range(0, 1) == 1);
      step(0);
    end
    repeat (4) step(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
